// File: rtl/mem_responder.sv
// Memory-side responder for the VeriRISC bus: synchronous word memory with a wait-state read engine.
// Optional protocol checker enabled by defining MEM_PROT_CHECK_EN.
module mem_responder #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              ready,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR_ACK} state_t;

    state_t            r_state;
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic              r_rd_q;
    logic              r_wr_q;
    logic [AWIDTH-1:0] r_addr_q;
    logic [2:0]        r_cnt;
    logic [DWIDTH-1:0] r_data_out;
    logic              r_ready;

    logic              w_rd_rise;
    logic              w_wr_rise;
    logic              w_wr_accept;
    logic              w_mem_we;
    logic [AWIDTH-1:0] w_idx;
    logic [AWIDTH-1:0] w_idx_q;

    assign w_rd_rise   = rd & ~r_rd_q;
    assign w_wr_rise   = wr & ~r_wr_q;
    assign w_wr_accept = (r_state == IDLE) && w_wr_rise;

    // Out-of-range addresses alias onto the physical words
    assign w_idx   = AWIDTH'(32'(addr) % DEPTH);
    assign w_idx_q = AWIDTH'(32'(r_addr_q) % DEPTH);

`ifdef MEM_PROT_CHECK_EN
    logic r_err;
    logic w_err_evt;

    assign w_mem_we  = w_wr_accept && data_e;
    assign w_err_evt = (w_wr_rise && !data_e)
                    || (rd && wr)
                    || ((r_state == RD_WAIT) && (addr != r_addr_q))
                    || (w_wr_rise && (r_state != IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_data_e;

    assign w_unused_data_e = data_e;
    assign w_mem_we        = w_wr_accept;
    assign err             = 1'b0;
`endif

    // Memory contents survive reset, so the array lives in its own reset-free block
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rd_q     <= 1'b0;
            r_wr_q     <= 1'b0;
            r_addr_q   <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_rd_q <= rd;
            r_wr_q <= wr;
            case (r_state)
                IDLE: begin
                    if (w_wr_rise) begin
                        r_ready <= 1'b1;
                        r_state <= WR_ACK;
                    end else if (w_rd_rise) begin
                        r_addr_q <= addr;
                        if (WAIT_STATES == 0) begin
                            r_data_out <= r_mem[w_idx];
                            r_ready    <= 1'b1;
                            r_state    <= RD_HOLD;
                        end else begin
                            r_cnt   <= 3'(WAIT_STATES);
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Dropping rd before the data is ready abandons the access
                    if (!rd) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == 3'd1) begin
                        r_data_out <= r_mem[w_idx_q];
                        r_ready    <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RD_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_HOLD: begin
                    if (!rd) begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WR_ACK: begin
                    r_ready <= 1'b0;
                    if (!wr) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign ready    = r_ready;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (0 and 2 wait states) share one stimulus stream.
// Expectations for the data_e/err cases follow MEM_PROT_CHECK_EN.
module tb_mem_responder;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DP = 24;

    typedef struct {
        bit           is_wr;
        logic [DW-1:0] data;
        int           delta;
        int           len;
        int           start;
    } sb_t;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     addr;
    logic              rd;
    logic              wr;
    logic              data_e;
    logic [DW-1:0]     data_in;
    logic [1:0][DW-1:0] dout;
    logic [1:0]        rdy;
    logic [1:0]        errs;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    sb_t q0[$];
    sb_t q1[$];

`ifdef MEM_PROT_CHECK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DP), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
        .data_in(data_in), .data_out(dout[0]), .ready(rdy[0]), .err(errs[0])
    );

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DP), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
        .data_in(data_in), .data_out(dout[1]), .ready(rdy[1]), .err(errs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic push(input int i, input sb_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: pops one entry per ready pulse and checks latency, data and pulse width
    sb_t cur [2];
    bit  have_cur [2];
    bit  prev_rdy [2];
    int  hi_cnt [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rdy[i] && !prev_rdy[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    chk($sformatf("dut%0d_unexpected_ready", i), 32'd1, 32'd0);
                    have_cur[i] = 1'b0;
                end else begin
                    cur[i]      = (i == 0) ? q0.pop_front() : q1.pop_front();
                    have_cur[i] = 1'b1;
                    hi_cnt[i]   = 1;
                    chk($sformatf("dut%0d_latency", i), 32'(cyc - cur[i].start), 32'(cur[i].delta));
                    if (!cur[i].is_wr)
                        chk($sformatf("dut%0d_rd_data", i), 32'(dout[i]), 32'(cur[i].data));
                end
            end else if (rdy[i] && prev_rdy[i]) begin
                hi_cnt[i]++;
                if (have_cur[i] && !cur[i].is_wr)
                    chk($sformatf("dut%0d_rd_hold", i), 32'(dout[i]), 32'(cur[i].data));
            end else if (!rdy[i] && prev_rdy[i]) begin
                if (have_cur[i] && cur[i].len != 0)
                    chk($sformatf("dut%0d_ready_len", i), 32'(hi_cnt[i]), 32'(cur[i].len));
                have_cur[i] = 1'b0;
            end
            prev_rdy[i] = rdy[i];
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic de);
        sb_t e;
        @(negedge clk);
        addr = a; data_in = d; data_e = de; wr = 1'b1;
        e = '{is_wr: 1'b1, data: '0, delta: 0, len: 1, start: cyc + 1};
        push(0, e);
        push(1, e);
        @(negedge clk);
        wr = 1'b0; data_e = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int h, input logic [DW-1:0] d);
        sb_t e;
        @(negedge clk);
        addr = a; rd = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (h > ws(i)) begin
                e = '{is_wr: 1'b0, data: d, delta: ws(i), len: h - ws(i), start: cyc + 1};
                push(i, e);
            end
        end
        repeat (h) @(negedge clk);
        rd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_err(input string tag, input logic exp);
        chk({tag, "_err_dut0"}, 32'(errs[0]), 32'(exp));
        chk({tag, "_err_dut1"}, 32'(errs[1]), 32'(exp));
    endtask

    initial begin
        sb_t e;
        rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ready_dut%0d", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("reset_dout_dut%0d", i), 32'(dout[i]), 32'd0);
            chk($sformatf("reset_err_dut%0d", i), 32'(errs[i]), 32'd0);
        end
        rst = 1'b0;

        do_write(5'd3, 8'hA5, 1'b1);
        do_write(5'd7, 8'h3C, 1'b1);
        do_write(5'd10, 8'h5A, 1'b1);
        do_write(5'd2, 8'hFF, 1'b1);
        do_write(5'd5, 8'h44, 1'b1);

        do_read(5'd3, 3, 8'hA5);
        do_read(5'd7, 5, 8'h3C);
        do_read(5'd10, 4, 8'h5A);

        // Short rd: the 2-wait-state instance must abort, the 0-wait one completes
        do_read(5'd7, 1, 8'h3C);
        chk("abort_dout_dut1", 32'(dout[1]), 32'h5A);
        chk("abort_dout_dut0", 32'(dout[0]), 32'h3C);
        do_read(5'd10, 4, 8'h5A);

        do_write(5'd25, 8'h77, 1'b1);
        do_read(5'd1, 3, 8'h77);
        do_read(5'd25, 3, 8'h77);
        chk_err("after_normal", 1'b0);

        do_write(5'd5, 8'h66, 1'b0);
        do_read(5'd5, 3, PROT ? 8'h44 : 8'h66);
        chk_err("after_de_low", PROT);

        // rd and wr rise together: write wins, no read response
        @(negedge clk);
        addr = 5'd4; data_in = 8'h11; data_e = 1'b1; wr = 1'b1; rd = 1'b1;
        e = '{is_wr: 1'b1, data: '0, delta: 0, len: 1, start: cyc + 1};
        push(0, e);
        push(1, e);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; data_e = 1'b0;
        repeat (3) @(negedge clk);
        chk_err("after_rd_wr", PROT);
        do_read(5'd4, 3, 8'h11);
        chk_err("err_sticky", PROT);

        // Asynchronous reset while both instances sit in RD_HOLD
        @(negedge clk);
        addr = 5'd2; rd = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = '{is_wr: 1'b0, data: 8'hFF, delta: ws(i), len: 0, start: cyc + 1};
            push(i, e);
        end
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_rst_ready_dut%0d", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("async_rst_dout_dut%0d", i), 32'(dout[i]), 32'd0);
            chk($sformatf("async_rst_err_dut%0d", i), 32'(errs[i]), 32'd0);
        end
        @(negedge clk);
        rd = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        do_read(5'd2, 3, 8'hFF);

        repeat (4) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
